// File: rtl/msi_cpu_controller_pkg.sv
// Shared MSI coherence types: line states and bus commands used by the
// cache unit, the snoop controller and the CPU-side controller.
package msi_cpu_controller_pkg;

  typedef enum logic [1:0] {
    MSI_INVALID  = 2'd0,
    MSI_SHARED   = 2'd1,
    MSI_MODIFIED = 2'd2
  } msi_state_t;

  typedef enum logic [2:0] {
    BUS_NONE           = 3'd0,
    BUS_READ           = 3'd1,
    BUS_READ_EXCLUSIVE = 3'd2,
    BUS_INVALIDATE     = 3'd3,
    BUS_WRITE_BACK     = 3'd4
  } bus_cmd_t;

  // A write fill takes ownership so the pending write can land without another bus trip.
  function automatic bus_cmd_t fill_command(input logic is_write);
    return is_write ? BUS_READ_EXCLUSIVE : BUS_READ;
  endfunction

  function automatic msi_state_t fill_state(input logic is_write);
    return is_write ? MSI_MODIFIED : MSI_SHARED;
  endfunction

endpackage

// File: rtl/msi_cpu_controller.sv
// CPU-side MSI cache controller: serves hits combinationally and sequences
// write-back, line fill and upgrade-invalidate transactions on the bus.
module msi_cpu_controller
  import msi_cpu_controller_pkg::*;
#(
  parameter int TAG_WIDTH    = 6,
  parameter int INDEX_WIDTH  = 4,
  parameter int OFFSET_WIDTH = 2,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic                                         cpu_read,
  input  logic                                         cpu_write,
  input  logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0]                        cpu_data_in,
  output logic [DATA_WIDTH-1:0]                        cpu_data_out,
  output logic                                         cpu_function_complete,
  output logic [INDEX_WIDTH-1:0]                       cache_index,
  output logic [OFFSET_WIDTH-1:0]                      cache_offset,
  output logic [TAG_WIDTH-1:0]                         cache_tag_in,
  input  logic [TAG_WIDTH-1:0]                         cache_tag_out,
  input  logic [1:0]                                   cache_state_out,
  input  logic                                         cache_hit,
  input  logic [DATA_WIDTH-1:0]                        cache_data_out,
  output logic [DATA_WIDTH-1:0]                        cache_data_in,
  output logic [1:0]                                   cache_state_in,
  output logic                                         cache_write_tag,
  output logic                                         cache_write_state,
  output logic                                         cache_write_data,
  output logic                                         bus_request,
  input  logic                                         bus_grant,
  output logic [2:0]                                   bus_command,
  output logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] bus_address,
  output logic [DATA_WIDTH-1:0]                        bus_data_out,
  input  logic [DATA_WIDTH-1:0]                        bus_data_in,
  input  logic                                         bus_ack
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WRITE_BACK = 2'd1;
  localparam logic [1:0] FILL       = 2'd2;
  localparam logic [1:0] INVALIDATE = 2'd3;

  localparam logic [OFFSET_WIDTH-1:0] LAST_WORD = {OFFSET_WIDTH{1'b1}};

  logic [1:0]              state, state_next;
  logic [OFFSET_WIDTH-1:0] counter, counter_next;
  logic                    is_write, is_read;
  logic [TAG_WIDTH-1:0]    req_tag;
  logic [INDEX_WIDTH-1:0]  req_index;
  logic [OFFSET_WIDTH-1:0] req_offset;

  assign is_write   = cpu_write;
  assign is_read    = cpu_read & ~cpu_write;
  assign req_offset = cpu_address[OFFSET_WIDTH-1:0];
  assign req_index  = cpu_address[OFFSET_WIDTH+INDEX_WIDTH-1:OFFSET_WIDTH];
  assign req_tag    = cpu_address[TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH+INDEX_WIDTH];

  always_comb begin
    state_next            = state;
    counter_next          = counter;
    cpu_data_out          = '0;
    cpu_function_complete = 1'b0;
    cache_index           = req_index;
    cache_offset          = req_offset;
    cache_tag_in          = req_tag;
    cache_data_in         = '0;
    cache_state_in        = MSI_INVALID;
    cache_write_tag       = 1'b0;
    cache_write_state     = 1'b0;
    cache_write_data      = 1'b0;
    bus_request           = 1'b0;
    bus_command           = BUS_NONE;
    bus_address           = {req_tag, req_index, counter};
    bus_data_out          = '0;

    // Reset overrides everything so no strobe or bus command escapes mid-transfer.
    if (reset) begin
      state_next   = IDLE;
      counter_next = '0;
    end else begin
      bus_request = (state != IDLE);
      case (state)
        IDLE: begin
          if (is_write && cache_hit) begin
            if (cache_state_out == MSI_MODIFIED) begin
              cache_write_data      = 1'b1;
              cache_data_in         = cpu_data_in;
              cpu_function_complete = 1'b1;
            end else begin
              state_next = INVALIDATE;
            end
          end else if (is_read && cache_hit) begin
            cpu_data_out          = cache_data_out;
            cpu_function_complete = 1'b1;
          end else if (is_write || is_read) begin
            counter_next = '0;
            state_next   = (cache_state_out == MSI_MODIFIED) ? WRITE_BACK : FILL;
          end else begin
            state_next = IDLE;
          end
        end

        INVALIDATE: begin
          if (bus_grant) begin
            bus_command           = BUS_INVALIDATE;
            cache_write_data      = 1'b1;
            cache_data_in         = cpu_data_in;
            cache_write_state     = 1'b1;
            cache_state_in        = MSI_MODIFIED;
            cpu_function_complete = 1'b1;
            state_next            = IDLE;
          end else begin
            state_next = INVALIDATE;
          end
        end

        WRITE_BACK: begin
          cache_offset = counter;
          bus_address  = {cache_tag_out, req_index, counter};
          if (bus_grant) begin
            bus_command  = BUS_WRITE_BACK;
            bus_data_out = cache_data_out;
            if (bus_ack) begin
              counter_next = counter + OFFSET_WIDTH'(1);
              if (counter == LAST_WORD) begin
                state_next = FILL;
              end else begin
                state_next = WRITE_BACK;
              end
            end else begin
              state_next = WRITE_BACK;
            end
          end else begin
            state_next = WRITE_BACK;
          end
        end

        FILL: begin
          cache_offset = counter;
          if (bus_grant) begin
            bus_command = fill_command(is_write);
            if (bus_ack) begin
              cache_write_data = 1'b1;
              cache_data_in    = bus_data_in;
              counter_next     = counter + OFFSET_WIDTH'(1);
              // Tag and state land with the last word; the request then completes as a hit in IDLE.
              if (counter == LAST_WORD) begin
                cache_write_tag   = 1'b1;
                cache_write_state = 1'b1;
                cache_state_in    = fill_state(is_write);
                state_next        = IDLE;
              end else begin
                state_next = FILL;
              end
            end else begin
              state_next = FILL;
            end
          end else begin
            state_next = FILL;
          end
        end

        default: begin
          state_next   = IDLE;
          counter_next = '0;
        end
      endcase
    end
  end

  // State and word-counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
    end
  end

endmodule
